store_stream_checker: RTL and testbench

- Sits directly downstream of the processor data-memory write port (memwrite/dataadr/writedata) in the simulation harness.
- Holds a small table of expected stores and checks them in order against the live store stream.
- Applies a cycle timeout and reports pass or fail, with a diagnostic capture.
- Replaces per-test hand-coded compare logic in the bench with one reusable, loadable checker.

---
 rtl/store_stream_checker.sv | 186 ++++++++++++++++++
 tb/tb_store_stream_checker.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_stream_checker.sv
// Checks the processor store stream, in order, against a loaded table of expected
// stores; reports pass/fail with a cycle timeout and first-mismatch capture.
module store_stream_checker #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 198,
    parameter int unsigned STRICT  = 0,
    parameter int unsigned CW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          exp_wr,
    input  logic [31:0]   exp_adr,
    input  logic [31:0]   exp_data,
    input  logic          start,
    input  logic          memwrite,
    input  logic [31:0]   dataadr,
    input  logic [31:0]   writedata,
    output logic          exp_full,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [CW-1:0] matched,
    output logic [15:0]   mismatches,
    output logic [31:0]   cycles,
    output logic [31:0]   bad_adr,
    output logic [31:0]   bad_data
);
    localparam int unsigned AW = CW - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_tbl_adr  [DEPTH];
    logic [31:0]   r_tbl_data [DEPTH];
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_ptr;
    logic [CW-1:0] r_matched;
    logic [15:0]   r_mismatches;
    logic [31:0]   r_cycles;
    logic [31:0]   r_bad_adr;
    logic [31:0]   r_bad_data;
    logic          r_timeout;

    logic          w_full;
    logic          w_load;
    logic          w_hit;
    logic          w_miss;
    logic          w_last;
    logic          w_to_edge;
    logic          w_done_pass;
    logic          w_fail_strict;
    logic          w_fail_to;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_wr_idx = r_count[AW-1:0];
    assign w_rd_idx = r_ptr[AW-1:0];
    assign w_load   = (r_state == S_IDLE) && exp_wr && !start && !clear && !w_full;

    // Case equality: any X/Z on the bus can never be taken as a match.
    assign w_hit         = memwrite &&
                           ({dataadr, writedata} === {r_tbl_adr[w_rd_idx], r_tbl_data[w_rd_idx]});
    assign w_miss        = memwrite && !w_hit;
    assign w_last        = (r_ptr == r_count - CW'(1));
    assign w_to_edge     = (r_cycles == 32'(TIMEOUT - 1));
    assign w_done_pass   = w_hit && w_last;
    assign w_fail_strict = w_miss && (STRICT != 0);
    assign w_fail_to     = w_to_edge && !w_done_pass && !w_fail_strict;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (r_count == '0) begin
                        w_state_nxt = S_PASS;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_done_pass) begin
                    w_state_nxt = S_PASS;
                end else if (w_fail_strict || w_to_edge) begin
                    w_state_nxt = S_FAIL;
                end
            end
            default: begin
            end
        endcase
        if (clear) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_tbl_adr[w_wr_idx]  <= exp_adr;
            r_tbl_data[w_wr_idx] <= exp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_ptr        <= '0;
            r_matched    <= '0;
            r_mismatches <= '0;
            r_cycles     <= '0;
            r_bad_adr    <= '0;
            r_bad_data   <= '0;
            r_timeout    <= 1'b0;
        end else if (clear) begin
            r_count      <= '0;
            r_ptr        <= '0;
            r_matched    <= '0;
            r_mismatches <= '0;
            r_cycles     <= '0;
            r_bad_adr    <= '0;
            r_bad_data   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr        <= '0;
                        r_matched    <= '0;
                        r_mismatches <= '0;
                        r_cycles     <= '0;
                        r_bad_adr    <= '0;
                        r_bad_data   <= '0;
                        r_timeout    <= 1'b0;
                    end else if (w_load) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_RUN: begin
                    if (r_cycles != '1) begin
                        r_cycles <= r_cycles + 32'd1;
                    end
                    if (w_hit) begin
                        r_ptr     <= r_ptr + CW'(1);
                        r_matched <= r_matched + CW'(1);
                    end
                    if (w_miss) begin
                        if (r_mismatches != '1) begin
                            r_mismatches <= r_mismatches + 16'd1;
                        end
                        // Mismatch count never wraps, so zero marks the first one of the run.
                        if (r_mismatches == '0) begin
                            r_bad_adr  <= dataadr;
                            r_bad_data <= writedata;
                        end
                    end
                    r_timeout <= w_fail_to;
                end
                default: begin
                end
            endcase
        end
    end

    assign exp_full   = w_full;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_PASS) || (r_state == S_FAIL);
    assign pass       = (r_state == S_PASS);
    assign timeout    = r_timeout;
    assign matched    = r_matched;
    assign mismatches = r_mismatches;
    assign cycles     = r_cycles;
    assign bad_adr    = r_bad_adr;
    assign bad_data   = r_bad_data;
endmodule

// File: tb/tb_store_stream_checker.sv
// Bench for store_stream_checker: directed scenarios plus randomized store streams
// scored against an in-order expected-store model, for lenient and strict instances.
module tb_store_stream_checker;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 198;
    localparam int unsigned CW      = 4;
    localparam int          NSCH    = TIMEOUT + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clear, exp_wr, start, memwrite;
    logic [31:0] exp_adr, exp_data, dataadr, writedata;

    logic          s0_full, s0_busy, s0_done, s0_pass, s0_to;
    logic [CW-1:0] s0_matched;
    logic [15:0]   s0_mism;
    logic [31:0]   s0_cycles, s0_bad_adr, s0_bad_data;
    logic          s1_full, s1_busy, s1_done, s1_pass, s1_to;
    logic [CW-1:0] s1_matched;
    logic [15:0]   s1_mism;
    logic [31:0]   s1_cycles, s1_bad_adr, s1_bad_data;

    store_stream_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(0), .CW(CW)) u_lenient (
        .clk(clk), .reset(reset), .clear(clear), .exp_wr(exp_wr), .exp_adr(exp_adr),
        .exp_data(exp_data), .start(start), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_full(s0_full), .busy(s0_busy), .done(s0_done),
        .pass(s0_pass), .timeout(s0_to), .matched(s0_matched), .mismatches(s0_mism),
        .cycles(s0_cycles), .bad_adr(s0_bad_adr), .bad_data(s0_bad_data)
    );

    store_stream_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(1), .CW(CW)) u_strict (
        .clk(clk), .reset(reset), .clear(clear), .exp_wr(exp_wr), .exp_adr(exp_adr),
        .exp_data(exp_data), .start(start), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_full(s1_full), .busy(s1_busy), .done(s1_done),
        .pass(s1_pass), .timeout(s1_to), .matched(s1_matched), .mismatches(s1_mism),
        .cycles(s1_cycles), .bad_adr(s1_bad_adr), .bad_data(s1_bad_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ent_adr [DEPTH];
    logic [31:0] ent_dat [DEPTH];
    int          n_ent;
    logic        sch_v [NSCH];
    logic [31:0] sch_a [NSCH];
    logic [31:0] sch_d [NSCH];
    int          d0_k, d1_k;

    bit          e_pass, e_to;
    int          e_matched, e_mism, e_cycles, e_donek;
    logic [31:0] e_bad_adr, e_bad_data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int k = 0; k < NSCH; k++) begin
            sch_v[k] = 1'b0;
            sch_a[k] = $urandom;
            sch_d[k] = $urandom;
        end
    endtask

    // Clear, load the table, start, then play the per-cycle store schedule.
    task automatic drive_run();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < n_ent; i++) begin
            exp_wr = 1'b1; exp_adr = ent_adr[i]; exp_data = ent_dat[i];
            step();
        end
        exp_wr = 1'b0;
        start  = 1'b1;
        step();
        start = 1'b0;
        d0_k = -1;
        d1_k = -1;
        for (int k = 0; k < NSCH; k++) begin
            memwrite = sch_v[k]; dataadr = sch_a[k]; writedata = sch_d[k];
            step();
            if (s0_done === 1'b1 && d0_k < 0) d0_k = k;
            if (s1_done === 1'b1 && d1_k < 0) d1_k = k;
        end
        memwrite = 1'b0;
    endtask

    // Expected outcome: walk the schedule, matching stores in table order.
    task automatic model_run(input bit strict);
        int ptr;
        bit fin;
        ptr = 0; fin = 1'b0;
        e_pass = 1'b0; e_to = 1'b0; e_mism = 0; e_cycles = 0; e_donek = -1;
        e_bad_adr = '0; e_bad_data = '0;
        for (int k = 0; k < int'(TIMEOUT) && !fin; k++) begin
            if (sch_v[k]) begin
                if (sch_a[k] == ent_adr[ptr] && sch_d[k] == ent_dat[ptr]) begin
                    ptr++;
                    if (ptr == n_ent) begin
                        e_pass = 1'b1;
                        fin = 1'b1;
                    end
                end else begin
                    if (e_mism == 0) begin
                        e_bad_adr = sch_a[k];
                        e_bad_data = sch_d[k];
                    end
                    e_mism++;
                    if (strict) fin = 1'b1;
                end
            end
            if (!fin && k == int'(TIMEOUT) - 1) begin
                e_to = 1'b1;
                fin = 1'b1;
            end
            if (fin) begin
                e_cycles = k + 1;
                e_donek = k;
            end
        end
        e_matched = ptr;
    endtask

    task automatic gen_random();
        int gptr, idle_w, r;
        gptr = 0;
        n_ent = $urandom_range(1, DEPTH);
        for (int i = 0; i < n_ent; i++) begin
            ent_adr[i] = $urandom & 32'hFFFF_FFFC;
            ent_dat[i] = $urandom;
        end
        idle_w = $urandom_range(2, 120);
        clear_sched();
        for (int k = 0; k < NSCH; k++) begin
            r = $urandom_range(0, idle_w + 6);
            if (r < idle_w) begin
                sch_v[k] = 1'b0;
            end else if (r < idle_w + 4) begin
                if (gptr < n_ent) begin
                    sch_v[k] = 1'b1; sch_a[k] = ent_adr[gptr]; sch_d[k] = ent_dat[gptr];
                    gptr++;
                end
            end else if (r == idle_w + 4 && gptr + 1 < n_ent) begin
                sch_v[k] = 1'b1; sch_a[k] = ent_adr[gptr + 1]; sch_d[k] = ent_dat[gptr + 1];
            end else begin
                sch_v[k] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({s0_full, s0_busy, s0_done, s0_pass, s0_to} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {s0_full, s0_busy, s0_done, s0_pass, s0_to});
        else n_pass++;
        n_checks++;
        if (s0_matched !== '0 || s0_mism !== '0 || s0_cycles !== '0)
            $display("FAIL reset_counters: matched=%0d mism=%0d cycles=%0d want 0", s0_matched, s0_mism, s0_cycles);
        else n_pass++;
        n_checks++;
        if (s0_bad_adr !== '0 || s0_bad_data !== '0)
            $display("FAIL reset_bad: adr=%h data=%h want 0", s0_bad_adr, s0_bad_data);
        else n_pass++;
        n_checks++;
        if ({s1_full, s1_busy, s1_done, s1_pass, s1_to} !== 5'b0)
            $display("FAIL reset_flags_strict: got %b want 00000", {s1_full, s1_busy, s1_done, s1_pass, s1_to});
        else n_pass++;
    endtask

    task automatic test_skip_mismatch();
        n_ent = 1; ent_adr[0] = 32'd18; ent_dat[0] = 32'd21;
        clear_sched();
        sch_v[0] = 1'b1; sch_a[0] = 32'd84; sch_d[0] = 32'd7;
        sch_v[20] = 1'b1; sch_a[20] = 32'd18; sch_d[20] = 32'd21;
        drive_run();
        n_checks++;
        if (s0_pass !== 1'b1 || s0_to !== 1'b0)
            $display("FAIL skip_status: pass=%b timeout=%b want 1/0", s0_pass, s0_to);
        else n_pass++;
        n_checks++;
        if (s0_matched !== 4'd1 || s0_mism !== 16'd1)
            $display("FAIL skip_counts: matched=%0d mism=%0d want 1/1", s0_matched, s0_mism);
        else n_pass++;
        n_checks++;
        if (s0_bad_adr !== 32'd84 || s0_bad_data !== 32'd7)
            $display("FAIL skip_bad: adr=%0d data=%0d want 84/7", s0_bad_adr, s0_bad_data);
        else n_pass++;
        n_checks++;
        if (d0_k !== 20 || s0_cycles !== 32'd21)
            $display("FAIL skip_timing: done_k=%0d cycles=%0d want 20/21", d0_k, s0_cycles);
        else n_pass++;
    endtask

    task automatic test_strict_fail();
        n_ent = 1; ent_adr[0] = 32'h70f0_0ff0; ent_dat[0] = 32'd2;
        clear_sched();
        sch_v[0] = 1'b1; sch_a[0] = 32'h70f0_0ff0; sch_d[0] = 32'd3;
        sch_v[3] = 1'b1; sch_a[3] = 32'h70f0_0ff0; sch_d[3] = 32'd2;
        drive_run();
        n_checks++;
        if (s1_done !== 1'b1 || s1_pass !== 1'b0 || s1_to !== 1'b0)
            $display("FAIL strict_status: done=%b pass=%b timeout=%b want 1/0/0", s1_done, s1_pass, s1_to);
        else n_pass++;
        n_checks++;
        if (s1_bad_adr !== 32'h70f0_0ff0 || s1_bad_data !== 32'd3)
            $display("FAIL strict_bad: adr=%h data=%0d want 70f00ff0/3", s1_bad_adr, s1_bad_data);
        else n_pass++;
        n_checks++;
        if (d1_k !== 0)
            $display("FAIL strict_latency: done_k=%0d want 0", d1_k);
        else n_pass++;
        n_checks++;
        if (s0_pass !== 1'b1 || s0_matched !== 4'd1)
            $display("FAIL strict_lenient_peer: pass=%b matched=%0d want 1/1", s0_pass, s0_matched);
        else n_pass++;
    endtask

    task automatic load_three();
        n_ent = 3;
        ent_adr[0] = 32'h2c;       ent_dat[0] = 32'd9;
        ent_adr[1] = 32'h30;       ent_dat[1] = 32'd1;
        ent_adr[2] = 32'h0fff_fffc; ent_dat[2] = 32'h3f8;
    endtask

    task automatic test_in_order();
        load_three();
        clear_sched();
        sch_v[2] = 1'b1; sch_a[2] = ent_adr[0]; sch_d[2] = ent_dat[0];
        sch_v[5] = 1'b1; sch_a[5] = ent_adr[1]; sch_d[5] = ent_dat[1];
        sch_v[9] = 1'b1; sch_a[9] = ent_adr[2]; sch_d[9] = ent_dat[2];
        drive_run();
        n_checks++;
        if (s0_pass !== 1'b1 || s0_matched !== 4'd3 || s0_mism !== 16'd0)
            $display("FAIL order_pass: pass=%b matched=%0d mism=%0d want 1/3/0", s0_pass, s0_matched, s0_mism);
        else n_pass++;
        n_checks++;
        if (d0_k !== 9 || s0_cycles !== 32'd10)
            $display("FAIL order_timing: done_k=%0d cycles=%0d want 9/10", d0_k, s0_cycles);
        else n_pass++;
        n_checks++;
        if (s1_pass !== 1'b1 || s1_matched !== 4'd3)
            $display("FAIL order_strict: pass=%b matched=%0d want 1/3", s1_pass, s1_matched);
        else n_pass++;
    endtask

    task automatic test_swapped_timeout();
        load_three();
        clear_sched();
        sch_v[3] = 1'b1; sch_a[3] = ent_adr[1]; sch_d[3] = ent_dat[1];
        sch_v[8] = 1'b1; sch_a[8] = ent_adr[0]; sch_d[8] = ent_dat[0];
        drive_run();
        n_checks++;
        if (s0_done !== 1'b1 || s0_pass !== 1'b0 || s0_to !== 1'b1)
            $display("FAIL swap_status: done=%b pass=%b timeout=%b want 1/0/1", s0_done, s0_pass, s0_to);
        else n_pass++;
        n_checks++;
        if (s0_matched !== 4'd1 || s0_mism !== 16'd1)
            $display("FAIL swap_counts: matched=%0d mism=%0d want 1/1", s0_matched, s0_mism);
        else n_pass++;
        n_checks++;
        if (d0_k !== 197 || s0_cycles !== 32'd198)
            $display("FAIL swap_timeout_edge: done_k=%0d cycles=%0d want 197/198", d0_k, s0_cycles);
        else n_pass++;
        n_checks++;
        if (s0_bad_adr !== 32'h30 || s0_bad_data !== 32'd1)
            $display("FAIL swap_bad: adr=%h data=%0d want 30/1", s0_bad_adr, s0_bad_data);
        else n_pass++;
        n_checks++;
        if (d1_k !== 3 || s1_to !== 1'b0 || s1_pass !== 1'b0)
            $display("FAIL swap_strict: done_k=%0d timeout=%b pass=%b want 3/0/0", d1_k, s1_to, s1_pass);
        else n_pass++;
    endtask

    task automatic test_timeout_edge();
        n_ent = 1; ent_adr[0] = 32'hA5A5_0000; ent_dat[0] = 32'h1234_5678;
        clear_sched();
        sch_v[TIMEOUT-1] = 1'b1; sch_a[TIMEOUT-1] = ent_adr[0]; sch_d[TIMEOUT-1] = ent_dat[0];
        drive_run();
        n_checks++;
        if (s0_pass !== 1'b1 || s0_to !== 1'b0 || d0_k !== 197)
            $display("FAIL edge_match_wins: pass=%b timeout=%b done_k=%0d want 1/0/197", s0_pass, s0_to, d0_k);
        else n_pass++;
        clear_sched();
        sch_v[TIMEOUT] = 1'b1; sch_a[TIMEOUT] = ent_adr[0]; sch_d[TIMEOUT] = ent_dat[0];
        drive_run();
        n_checks++;
        if (s0_pass !== 1'b0 || s0_to !== 1'b1 || s0_matched !== 4'd0 || d0_k !== 197)
            $display("FAIL edge_too_late: pass=%b timeout=%b matched=%0d done_k=%0d want 0/1/0/197",
                     s0_pass, s0_to, s0_matched, d0_k);
        else n_pass++;
    endtask

    task automatic test_capacity();
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_wr = 1'b1; exp_adr = 32'h1000 + 32'(4 * i); exp_data = 32'(3 * i + 1);
            step();
        end
        exp_wr = 1'b0;
        n_checks++;
        if (s0_full !== 1'b1) $display("FAIL cap_full: got %b want 1", s0_full);
        else n_pass++;
        exp_wr = 1'b1; exp_adr = 32'hDEAD_0000; exp_data = 32'hBEEF;
        step();
        exp_wr = 1'b0;
        n_checks++;
        if (s0_full !== 1'b1 || s0_busy !== 1'b0) $display("FAIL cap_ninth: full=%b busy=%b want 1/0", s0_full, s0_busy);
        else n_pass++;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            memwrite = 1'b1; dataadr = 32'h1000 + 32'(4 * i); writedata = 32'(3 * i + 1);
            step();
        end
        memwrite = 1'b0;
        n_checks++;
        if (s0_pass !== 1'b1 || s0_matched !== 4'd8)
            $display("FAIL cap_run: pass=%b matched=%0d want 1/8", s0_pass, s0_matched);
        else n_pass++;
        clear = 1'b1; step(); clear = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        n_checks++;
        if (s0_pass !== 1'b1 || s0_done !== 1'b1 || s0_matched !== 4'd0 || s0_cycles !== 32'd0)
            $display("FAIL empty_start: pass=%b done=%b matched=%0d cycles=%0d want 1/1/0/0",
                     s0_pass, s0_done, s0_matched, s0_cycles);
        else n_pass++;
    endtask

    task automatic test_start_wins();
        clear = 1'b1; step(); clear = 1'b0;
        exp_wr = 1'b1; exp_adr = 32'h40; exp_data = 32'h44; step();
        start = 1'b1; exp_adr = 32'h80; exp_data = 32'h88; step();
        start = 1'b0; exp_wr = 1'b0;
        n_checks++;
        if (s0_busy !== 1'b1) $display("FAIL startwr_busy: got %b want 1", s0_busy);
        else n_pass++;
        memwrite = 1'b1; dataadr = 32'h40; writedata = 32'h44; step();
        memwrite = 1'b0;
        n_checks++;
        if (s0_pass !== 1'b1 || s0_matched !== 4'd1)
            $display("FAIL startwr_drop: pass=%b matched=%0d want 1/1", s0_pass, s0_matched);
        else n_pass++;
    endtask

    task automatic test_abort_reset();
        clear = 1'b1; step(); clear = 1'b0;
        exp_wr = 1'b1; exp_adr = 32'h100; exp_data = 32'h1; step();
        exp_adr = 32'h104; step();
        exp_wr = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        n_checks++;
        if (s0_busy !== 1'b1 || s0_cycles !== 32'd3)
            $display("FAIL abort_pre: busy=%b cycles=%0d want 1/3", s0_busy, s0_cycles);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({s0_busy, s0_done, s0_pass, s0_to} !== 4'b0 || s0_cycles !== '0 || s1_busy !== 1'b0)
            $display("FAIL abort_async: busy=%b done=%b cycles=%0d strict_busy=%b want 0",
                     s0_busy, s0_done, s0_cycles, s1_busy);
        else n_pass++;
        step();
        reset = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        n_checks++;
        if (s0_pass !== 1'b1 || s0_cycles !== 32'd0)
            $display("FAIL abort_table_empty: pass=%b cycles=%0d want 1/0", s0_pass, s0_cycles);
        else n_pass++;
    endtask

    task automatic test_clear_in_fail();
        clear = 1'b1; step(); clear = 1'b0;
        exp_wr = 1'b1; exp_adr = 32'h200; exp_data = 32'h5; step();
        exp_wr = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        memwrite = 1'b1; dataadr = 32'h200; writedata = 32'h6; step();
        memwrite = 1'b0;
        n_checks++;
        if (s1_done !== 1'b1 || s1_pass !== 1'b0)
            $display("FAIL clear_pre: done=%b pass=%b want 1/0", s1_done, s1_pass);
        else n_pass++;
        clear = 1'b1; step(); clear = 1'b0;
        n_checks++;
        if (s1_done !== 1'b0 || s1_busy !== 1'b0 || s1_bad_data !== '0 || s1_mism !== '0)
            $display("FAIL clear_status: done=%b busy=%b bad_data=%h mism=%0d want 0",
                     s1_done, s1_busy, s1_bad_data, s1_mism);
        else n_pass++;
        start = 1'b1; step(); start = 1'b0;
        n_checks++;
        if (s1_pass !== 1'b1) $display("FAIL clear_count: pass=%b want 1 (empty table)", s1_pass);
        else n_pass++;
    endtask

    task automatic test_random_lenient();
        for (int s = 0; s < 6; s++) begin
            gen_random();
            drive_run();
            model_run(1'b0);
            n_checks++;
            if (s0_pass !== e_pass || s0_to !== e_to)
                $display("FAIL rnd_len[%0d] status: pass=%b to=%b want %b/%b", s, s0_pass, s0_to, e_pass, e_to);
            else n_pass++;
            n_checks++;
            if (s0_matched !== CW'(e_matched) || s0_mism !== 16'(e_mism))
                $display("FAIL rnd_len[%0d] counts: matched=%0d mism=%0d want %0d/%0d",
                         s, s0_matched, s0_mism, e_matched, e_mism);
            else n_pass++;
            n_checks++;
            if (s0_cycles !== 32'(e_cycles) || d0_k !== e_donek)
                $display("FAIL rnd_len[%0d] timing: cycles=%0d done_k=%0d want %0d/%0d",
                         s, s0_cycles, d0_k, e_cycles, e_donek);
            else n_pass++;
            n_checks++;
            if (s0_bad_adr !== e_bad_adr || s0_bad_data !== e_bad_data)
                $display("FAIL rnd_len[%0d] bad: adr=%h data=%h want %h/%h",
                         s, s0_bad_adr, s0_bad_data, e_bad_adr, e_bad_data);
            else n_pass++;
        end
    endtask

    task automatic test_random_strict();
        for (int s = 0; s < 6; s++) begin
            gen_random();
            drive_run();
            model_run(1'b1);
            n_checks++;
            if (s1_pass !== e_pass || s1_to !== e_to)
                $display("FAIL rnd_str[%0d] status: pass=%b to=%b want %b/%b", s, s1_pass, s1_to, e_pass, e_to);
            else n_pass++;
            n_checks++;
            if (s1_matched !== CW'(e_matched))
                $display("FAIL rnd_str[%0d] matched: got %0d want %0d", s, s1_matched, e_matched);
            else n_pass++;
            n_checks++;
            if (s1_cycles !== 32'(e_cycles) || d1_k !== e_donek)
                $display("FAIL rnd_str[%0d] timing: cycles=%0d done_k=%0d want %0d/%0d",
                         s, s1_cycles, d1_k, e_cycles, e_donek);
            else n_pass++;
            n_checks++;
            if (s1_bad_adr !== e_bad_adr || s1_bad_data !== e_bad_data)
                $display("FAIL rnd_str[%0d] bad: adr=%h data=%h want %h/%h",
                         s, s1_bad_adr, s1_bad_data, e_bad_adr, e_bad_data);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; exp_wr = 1'b0; start = 1'b0; memwrite = 1'b0;
        exp_adr = '0; exp_data = '0; dataadr = '0; writedata = '0;
        #12;
        test_reset();
        step();
        reset = 1'b1;
        step();
        test_skip_mismatch();
        test_strict_fail();
        test_in_order();
        test_swapped_timeout();
        test_timeout_edge();
        test_capacity();
        test_start_wins();
        test_abort_reset();
        test_clear_in_fail();
        test_random_lenient();
        test_random_strict();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
